// File: rtl/duc_fir_pkg.sv
// Shared constants and state encoding for the DUC FIR coefficient reload sequencer.
// Filter geometry: W1=16, L=16 taps, Mpipe=3 pipeline stages.
package duc_fir_pkg;
  localparam int NUM_TAPS  = 16;
  localparam int COEF_W    = 16;
  localparam int NUM_BANKS = 4;
  localparam int MPIPE     = 3;
  localparam int FLUSH_CYC = NUM_TAPS + MPIPE;
  localparam int BANK_W    = $clog2(NUM_BANKS);
  localparam int ADDR_W    = $clog2(NUM_TAPS);

  typedef enum logic [2:0] {IDLE, DRAIN, LOAD, SETTLE, DONE} state_e;
endpackage

// File: rtl/duc_fir_coef_ctrl_if.sv
// Config/reload/filter-load signal bundle of the coefficient sequencer.
// The "master" side is the config host plus the filter; "slave" is the sequencer.
interface duc_fir_coef_ctrl_if;
  import duc_fir_pkg::*;

  logic              i_wr_en;
  logic [BANK_W-1:0] i_wr_bank;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [COEF_W-1:0] i_wr_data;
  logic              i_reload_req;
  logic [BANK_W-1:0] i_reload_bank;
  logic              o_busy;
  logic              o_reload_ack;
  logic              o_req_err;
  logic              o_wr_err;
  logic              o_dp_hold;
  logic              o_load_parameter;
  logic [COEF_W-1:0] o_parameter_data;
  logic [BANK_W-1:0] o_active_bank;

  modport master (
    output i_wr_en, i_wr_bank, i_wr_addr, i_wr_data, i_reload_req, i_reload_bank,
    input  o_busy, o_reload_ack, o_req_err, o_wr_err, o_dp_hold,
           o_load_parameter, o_parameter_data, o_active_bank
  );

  modport slave (
    input  i_wr_en, i_wr_bank, i_wr_addr, i_wr_data, i_reload_req, i_reload_bank,
    output o_busy, o_reload_ack, o_req_err, o_wr_err, o_dp_hold,
           o_load_parameter, o_parameter_data, o_active_bank
  );
endinterface

// File: rtl/duc_coef_ram.sv
// Coefficient store: simple dual-port RAM, one write port, registered read port.
// Contents are intentionally not reset.
module duc_coef_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/duc_fir_coef_ctrl.sv
// Coefficient reload sequencer: drain the datapath, stream one bank into the
// filter's parameter port, settle, then release the upsampler hold.
module duc_fir_coef_ctrl
  import duc_fir_pkg::*;
(
  input logic                i_clk,
  input logic                i_rst,
  duc_fir_coef_ctrl_if.slave bus
);
  // One counter serves both the flush countdown and the tap address, so it
  // must reach FLUSH_CYC-1 and the one-past-last tap index.
  localparam int CNT_MAX = (FLUSH_CYC > NUM_TAPS + 1) ? FLUSH_CYC : NUM_TAPS + 1;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] TAP_END  = CNT_W'(NUM_TAPS);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [BANK_W-1:0] bank_q, active_q;
  logic              rd_en, rd_vld, req_q, req_err_q, wr_block;
  logic [COEF_W-1:0] rd_data;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_en     = 1'b0;
    case (state)
      IDLE: if (bus.i_reload_req) begin
        state_nxt = DRAIN;
        cnt_nxt   = FLUSH_LD;
      end
      DRAIN: if (cnt == '0) begin
        state_nxt = LOAD;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt - 1'b1;
      // Reads run for NUM_TAPS cycles; the extra cycle lets the last word leave the RAM.
      LOAD: if (cnt == TAP_END) begin
        state_nxt = SETTLE;
        cnt_nxt   = FLUSH_LD;
      end else begin
        rd_en   = 1'b1;
        cnt_nxt = cnt + 1'b1;
      end
      SETTLE: if (cnt == '0) state_nxt = DONE;
              else cnt_nxt = cnt - 1'b1;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bank_q    <= '0;
      active_q  <= '0;
      rd_vld    <= 1'b0;
      req_q     <= 1'b0;
      req_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rd_vld    <= rd_en;
      req_q     <= bus.i_reload_req;
      req_err_q <= bus.i_reload_req && !req_q && (state != IDLE);
      if (state == IDLE && bus.i_reload_req) bank_q <= bus.i_reload_bank;
      if (state == DONE) active_q <= bank_q;
    end
  end

  assign wr_block = (state == LOAD) && (bus.i_wr_bank == bank_q);

  duc_coef_ram #(
    .DEPTH (NUM_BANKS * NUM_TAPS),
    .AW    (BANK_W + ADDR_W),
    .DW    (COEF_W)
  ) u_ram (
    .clk   (i_clk),
    .we    (bus.i_wr_en && !wr_block),
    .waddr ({bus.i_wr_bank, bus.i_wr_addr}),
    .wdata (bus.i_wr_data),
    .re    (rd_en),
    .raddr ({bank_q, cnt[ADDR_W-1:0]}),
    .rdata (rd_data)
  );

  assign bus.o_busy           = (state != IDLE);
  assign bus.o_dp_hold        = (state != IDLE);
  assign bus.o_reload_ack     = (state == DONE);
  assign bus.o_req_err        = req_err_q;
  assign bus.o_wr_err         = bus.i_wr_en && wr_block;
  assign bus.o_load_parameter = rd_vld;
  assign bus.o_parameter_data = rd_vld ? rd_data : '0;
  assign bus.o_active_bank    = active_q;
endmodule

// File: tb/tb_duc_fir_coef_ctrl.sv
// Directed bench for the coefficient reload sequencer; cycle offsets are relative
// to the cycle in which the reload request is presented.
module tb_duc_fir_coef_ctrl;
  import duc_fir_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  duc_fir_coef_ctrl_if bus();
  duc_fir_coef_ctrl dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [COEF_W-1:0] model [NUM_BANKS][NUM_TAPS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    chk({tag, "_hold"}, 32'(bus.o_dp_hold), 0);
    chk({tag, "_load"}, 32'(bus.o_load_parameter), 0);
    chk({tag, "_data"}, 32'(bus.o_parameter_data), 0);
    chk({tag, "_ack"}, 32'(bus.o_reload_ack), 0);
    chk({tag, "_reqerr"}, 32'(bus.o_req_err), 0);
    chk({tag, "_wrerr"}, 32'(bus.o_wr_err), 0);
    chk({tag, "_bank"}, 32'(bus.o_active_bank), 0);
  endtask

  // Idle-time coefficient write, one cycle.
  task automatic wr(input int b, input int a, input logic [COEF_W-1:0] d);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_bank = BANK_W'(b);
    bus.i_wr_addr = ADDR_W'(a);
    bus.i_wr_data = d;
    model[b][a]   = d;
    @(negedge i_clk);
    chk("wr_err_idle", 32'(bus.o_wr_err), 0);
    @(posedge i_clk); #1;
    bus.i_wr_en = 1'b0;
  endtask

  // One reload sequence, offsets 0..56; returns at the start of offset 57.
  task automatic seq(input int bank, input int prev, input int pulse_at, input int wr_at,
                     input int wb, input int wa, input logic [COEF_W-1:0] wd,
                     input bit wr_drop, input int rst_at, input bit hold);
    for (int k = 0; k <= 56; k++) begin
      if (k == 0) begin
        bus.i_reload_req  = 1'b1;
        bus.i_reload_bank = BANK_W'(bank);
      end else if (k == pulse_at) bus.i_reload_req = 1'b1;
      else bus.i_reload_req = hold;
      bus.i_wr_en = (k == wr_at);
      if (k == wr_at) begin
        bus.i_wr_bank = BANK_W'(wb);
        bus.i_wr_addr = ADDR_W'(wa);
        bus.i_wr_data = wd;
        if (!wr_drop) model[wb][wa] = wd;
      end
      if (k == rst_at) begin
        #1 i_rst = 1'b0;
        bus.i_reload_req = 1'b0;
        bus.i_wr_en = 1'b0;
        #1 chk_all_zero($sformatf("rst@%0d", k));
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        return;
      end
      @(negedge i_clk);
      chk($sformatf("busy@%0d", k), 32'(bus.o_busy), 32'(k >= 1));
      chk($sformatf("hold@%0d", k), 32'(bus.o_dp_hold), 32'(k >= 1));
      chk($sformatf("load@%0d", k), 32'(bus.o_load_parameter), 32'(k >= 21 && k <= 36));
      chk($sformatf("data@%0d", k), 32'(bus.o_parameter_data),
          (k >= 21 && k <= 36) ? 32'(model[bank][k-21]) : 0);
      chk($sformatf("ack@%0d", k), 32'(bus.o_reload_ack), 32'(k == 56));
      chk($sformatf("reqerr@%0d", k), 32'(bus.o_req_err), 32'(pulse_at > 0 && k == pulse_at + 1));
      chk($sformatf("wrerr@%0d", k), 32'(bus.o_wr_err), 32'(k == wr_at && wr_drop));
      chk($sformatf("abank@%0d", k), 32'(bus.o_active_bank), 32'(prev));
      @(posedge i_clk); #1;
    end
    bus.i_wr_en = 1'b0;
  endtask

  initial begin
    bus.i_wr_en = 1'b0; bus.i_wr_bank = '0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_reload_req = 1'b0; bus.i_reload_bank = '0;
    repeat (2) @(posedge i_clk);
    #1 chk_all_zero("reset");
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    for (int a = 0; a < NUM_TAPS; a++) begin
      wr(0, a, 16'h1000 + 16'(a));
      wr(1, a, 16'(a + 1));
      wr(2, a, 16'h2000 + 16'(a));
      wr(3, a, 16'h3000 + 16'(a));
    end

    // Basic load of bank1 = 1..16.
    seq(1, 0, -1, -1, 0, 0, 16'h0, 1'b0, -1, 1'b0);
    // Request while busy flagged and dropped; active-bank reload is legal.
    seq(1, 1, 5, -1, 0, 0, 16'h0, 1'b0, -1, 1'b0);
    // Write to the bank under load is dropped.
    seq(1, 1, -1, 25, 1, 3, 16'hBEEF, 1'b1, -1, 1'b0);
    // Same write to a different bank lands, then gets loaded.
    seq(1, 1, -1, 25, 2, 3, 16'hBEEF, 1'b0, -1, 1'b0);
    seq(2, 1, -1, -1, 0, 0, 16'h0, 1'b0, -1, 1'b0);
    // DRAIN-time write to the latched bank is loaded.
    seq(3, 2, -1, 10, 3, 5, 16'h5555, 1'b0, -1, 1'b0);
    // Same-cycle write and request in IDLE.
    seq(0, 3, -1, 0, 0, 0, 16'h7FFF, 1'b0, -1, 1'b0);
    // Reset mid-LOAD, then a full sequence from scratch.
    seq(2, 0, -1, -1, 0, 0, 16'h0, 1'b0, 28, 1'b0);
    seq(2, 0, -1, -1, 0, 0, 16'h0, 1'b0, -1, 1'b0);
    // Request held high: second sequence starts after one IDLE cycle.
    seq(1, 2, -1, -1, 0, 0, 16'h0, 1'b0, -1, 1'b1);
    seq(3, 1, -1, -1, 0, 0, 16'h0, 1'b0, -1, 1'b0);

    @(negedge i_clk);
    chk("final_abank", 32'(bus.o_active_bank), 3);
    chk("final_busy", 32'(bus.o_busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
